// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter
// Two-requester (IF read-only, MEM read/write) arbiter in front of the
// single-port AXI bridge request interface. One request is outstanding at a
// time, round-robin decides between simultaneous requests, and the bridge
// response is routed back to whichever side won the grant.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts a
// grant after TIMEOUT_CYCLES cycles without out_done, returns zero data to
// the requester and raises the sticky timeout_err flag. Without the macro
// timeout_err is tied to 0 and a grant waits for out_done indefinitely.

module ysyx_22040759_mem_arbiter #(
    parameter int         ADDR_W         = 64,
    parameter int         DATA_W         = 64,
    parameter logic [1:0] IF_SIZE        = 2'b11,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,

    output logic              out_valid,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_size,
    output logic [DATA_W-1:0] out_wdata,
    input  logic              out_done,
    input  logic [DATA_W-1:0] out_rdata,

    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_IF  = 2'd1,
        ST_GNT_MEM = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // rr_ptr = 0 favours IF, 1 favours MEM when both request together.
    logic rr_ptr;
    logic rr_ptr_next;

    logic              grant_if;
    logic              grant_mem;
    logic              wdt_hit;

    logic              out_valid_next;
    logic              out_wen_next;
    logic [ADDR_W-1:0] out_addr_next;
    logic [1:0]        out_size_next;
    logic [DATA_W-1:0] out_wdata_next;
    logic              if_ready_next;
    logic [DATA_W-1:0] if_rdata_next;
    logic              mem_ready_next;
    logic [DATA_W-1:0] mem_rdata_next;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdt_cnt;
    logic [CNT_W-1:0] wdt_cnt_next;
    logic             timeout_err_q;
    logic             timeout_err_next;

    assign wdt_hit     = (wdt_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_q;

    // Watchdog counter and sticky error flag; only reset clears the flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_cnt       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdt_cnt       <= wdt_cnt_next;
            timeout_err_q <= timeout_err_next;
        end
    end
`else
    assign wdt_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration decision; only meaningful while in IDLE.
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state == ST_IDLE) begin
            if (if_valid && mem_valid) begin
                grant_if  = ~rr_ptr;
                grant_mem = rr_ptr;
            end else begin
                grant_if  = if_valid;
                grant_mem = mem_valid;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        next_state     = state;
        rr_ptr_next    = rr_ptr;
        out_valid_next = out_valid;
        out_wen_next   = out_wen;
        out_addr_next  = out_addr;
        out_size_next  = out_size;
        out_wdata_next = out_wdata;
        if_ready_next  = 1'b0;
        if_rdata_next  = if_rdata;
        mem_ready_next = 1'b0;
        mem_rdata_next = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        wdt_cnt_next     = wdt_cnt;
        timeout_err_next = timeout_err_q;
`endif

        case (state)
            ST_IDLE: begin
                if (grant_if) begin
                    next_state     = ST_GNT_IF;
                    rr_ptr_next    = 1'b1;
                    out_valid_next = 1'b1;
                    out_wen_next   = 1'b0;
                    out_addr_next  = if_addr;
                    out_size_next  = IF_SIZE;
                    out_wdata_next = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    wdt_cnt_next   = '0;
`endif
                end else if (grant_mem) begin
                    next_state     = ST_GNT_MEM;
                    rr_ptr_next    = 1'b0;
                    out_valid_next = 1'b1;
                    out_wen_next   = mem_wen;
                    out_addr_next  = mem_addr;
                    out_size_next  = mem_size;
                    out_wdata_next = mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                    wdt_cnt_next   = '0;
`endif
                end
            end

            ST_GNT_IF: begin
                if (out_done) begin
                    next_state     = ST_RESP;
                    out_valid_next = 1'b0;
                    if_rdata_next  = out_rdata;
                    if_ready_next  = 1'b1;
                end else if (wdt_hit) begin
                    next_state     = ST_RESP;
                    out_valid_next = 1'b0;
                    if_rdata_next  = '0;
                    if_ready_next  = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    timeout_err_next = 1'b1;
`endif
                end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wdt_cnt_next = wdt_cnt + 1'b1;
`endif
                end
            end

            ST_GNT_MEM: begin
                if (out_done) begin
                    next_state     = ST_RESP;
                    out_valid_next = 1'b0;
                    mem_rdata_next = out_rdata;
                    mem_ready_next = 1'b1;
                end else if (wdt_hit) begin
                    next_state     = ST_RESP;
                    out_valid_next = 1'b0;
                    mem_rdata_next = '0;
                    mem_ready_next = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    timeout_err_next = 1'b1;
`endif
                end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wdt_cnt_next = wdt_cnt + 1'b1;
`endif
                end
            end

            // One dead cycle so a requester can drop valid after its ready
            // pulse without being granted a second time.
            ST_RESP: begin
                next_state = ST_IDLE;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            out_addr  <= '0;
            out_size  <= 2'b00;
            out_wdata <= '0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= next_state;
            rr_ptr    <= rr_ptr_next;
            out_valid <= out_valid_next;
            out_wen   <= out_wen_next;
            out_addr  <= out_addr_next;
            out_size  <= out_size_next;
            out_wdata <= out_wdata_next;
            if_ready  <= if_ready_next;
            if_rdata  <= if_rdata_next;
            mem_ready <= mem_ready_next;
            mem_rdata <= mem_rdata_next;
        end
    end

endmodule
